// File: rtl/fb_fifo_reader_pkg.sv
// fb_fifo_reader_pkg: shared types, default parameters and the beats-per-word
// helper for the fb_fifo_reader drain engine.
package fb_fifo_reader_pkg;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_TIMEOUT   = 8;

  // Number of FIFO beats packed into one output word.
  function automatic int nb(input int out_width, input int width);
    return out_width / width;
  endfunction

endpackage

// File: rtl/fb_fifo_reader_pack.sv
// fb_fifo_reader_pack: assembly register for one output word. A write drops
// din into slot 'slot' and sets its mask bit; 'take' empties the register
// after the owner has captured word_next/mask_next (which already include
// any write made in the same cycle).
module fb_fifo_reader_pack
  import fb_fifo_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NB    = nb(DEF_OUT_WIDTH, DEF_WIDTH),
  parameter int CW    = $clog2(NB)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [CW-1:0]         slot,
  input  logic [WIDTH-1:0]      din,
  input  logic                  take,
  output logic [NB*WIDTH-1:0]   word_next,
  output logic [NB-1:0]         mask_next
);

  logic [NB*WIDTH-1:0] data_reg;
  logic [NB-1:0]       mask_reg;

  // Per-slot merge of the incoming beat over the held contents.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_slot
      logic hit;
      assign hit = wr && (slot == CW'(gi));
      assign word_next[gi*WIDTH +: WIDTH] = hit ? din : data_reg[gi*WIDTH +: WIDTH];
      assign mask_next[gi] = hit | mask_reg[gi];
    end
  endgenerate

  // Hold the partially assembled word; clear it once it has been handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      mask_reg <= '0;
    end else if (take) begin
      data_reg <= '0;
      mask_reg <= '0;
    end else begin
      data_reg <= word_next;
      mask_reg <= mask_next;
    end
  end

endmodule

// File: rtl/fb_fifo_reader.sv
// fb_fifo_reader: drains a first-word-fall-through fb_fifo, packs entries
// LSB-first into OUT_WIDTH-bit words and offers them on a valid/ready port
// with a per-beat mask. Partial words leave on 'flush'; with the macro
// FB_FIFO_READER_TIMEOUT_EN defined they also leave after TIMEOUT idle cycles.
module fb_fifo_reader
  import fb_fifo_reader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              fifo_empty,
  input  logic [WIDTH-1:0]                  fifo_out,
  output logic                              fifo_pop,
  input  logic                              flush,
  output logic                              dma_valid,
  input  logic                              dma_ready,
  output logic [OUT_WIDTH-1:0]              dma_data,
  output logic [nb(OUT_WIDTH, WIDTH)-1:0]   dma_mask,
  output logic                              busy
);

  localparam int NB = nb(OUT_WIDTH, WIDTH);
  localparam int CW = $clog2(NB);

  generate
    if ((OUT_WIDTH % WIDTH) != 0 || NB < 2) begin : g_bad_ratio
      $error("fb_fifo_reader: OUT_WIDTH must be a multiple of WIDTH with ratio >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fb_fifo_reader: TIMEOUT must be >= 1");
    end
  endgenerate

  state_e              state_reg;
  logic [CW-1:0]       cnt_reg;
  logic                last_beat;
  logic                timeout_hit;
  logic                flush_int;
  logic                take;
  logic [OUT_WIDTH-1:0] word_next;
  logic [NB-1:0]       mask_next;

  // Pop whenever there is data and somewhere to put it; a SEND-state pop only
  // happens alongside the handshake so the next word starts without a bubble.
  assign fifo_pop  = rst_n && !fifo_empty && ((state_reg == FILL) || dma_ready);
  assign last_beat = (cnt_reg == CW'(NB - 1));
  assign flush_int = flush || timeout_hit;
  assign take      = (state_reg == FILL) &&
                     ((fifo_pop && (last_beat || flush_int)) ||
                      (!fifo_pop && flush_int && (cnt_reg != '0)));
  assign busy      = (cnt_reg != '0) || dma_valid;

  fb_fifo_reader_pack #(
    .WIDTH (WIDTH),
    .NB    (NB),
    .CW    (CW)
  ) u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (fifo_pop),
    .slot      (cnt_reg),
    .din       (fifo_out),
    .take      (take),
    .word_next (word_next),
    .mask_next (mask_next)
  );

`ifdef FB_FIFO_READER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_reg;

  assign timeout_hit = (state_reg == FILL) && (idle_reg == IW'(TIMEOUT));

  // Count starved FILL cycles while a partial word is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_reg <= '0;
    end else if (fifo_pop || (state_reg == SEND)) begin
      idle_reg <= '0;
    end else if ((state_reg == FILL) && (cnt_reg != '0) && fifo_empty && !timeout_hit) begin
      idle_reg <= idle_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Fill/send sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FILL;
      cnt_reg   <= '0;
      dma_valid <= 1'b0;
      dma_data  <= '0;
      dma_mask  <= '0;
    end else begin
      case (state_reg)
        FILL: begin
          if (take) begin
            state_reg <= SEND;
            dma_valid <= 1'b1;
            dma_data  <= word_next;
            dma_mask  <= mask_next;
            cnt_reg   <= '0;
          end else if (fifo_pop) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        SEND: begin
          if (dma_ready) begin
            state_reg <= FILL;
            dma_valid <= 1'b0;
            // A beat popped during the handshake already sits in slot 0.
            cnt_reg   <= fifo_pop ? CW'(1) : '0;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

endmodule
